// File: rtl/emulib_rammodel_route_fifo.sv
// 1-bit synchronous FIFO recording which requester owns each accepted AW burst.
// The head is read asynchronously so the W mux can follow it in the same cycle.
module emulib_rammodel_route_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic          mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + PTR_ONE;
            if (pop && !empty)
                rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/emulib_rammodel_arbiter_2to1.sv
// Two-requester arbiter in front of one RAM-model timing-model port: round-robin
// AR/AW with requester index prepended to the ID, W routed in AW grant order.
module emulib_rammodel_arbiter_2to1 #(
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int W_FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    input  logic [ID_WIDTH-1:0]   s0_arid,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    input  logic                  s0_awvalid,
    output logic                  s0_awready,
    input  logic [ID_WIDTH-1:0]   s0_awid,
    input  logic [ADDR_WIDTH-1:0] s0_awaddr,
    input  logic [7:0]            s0_awlen,
    input  logic [2:0]            s0_awsize,
    input  logic [1:0]            s0_awburst,
    input  logic                  s0_wvalid,
    output logic                  s0_wready,
    input  logic                  s0_wlast,
    output logic                  s0_bvalid,
    input  logic                  s0_bready,
    output logic [ID_WIDTH-1:0]   s0_bid,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    output logic [ID_WIDTH-1:0]   s0_rid,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    input  logic [ID_WIDTH-1:0]   s1_arid,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    input  logic [ID_WIDTH-1:0]   s1_awid,
    input  logic [ADDR_WIDTH-1:0] s1_awaddr,
    input  logic [7:0]            s1_awlen,
    input  logic [2:0]            s1_awsize,
    input  logic [1:0]            s1_awburst,
    input  logic                  s1_wvalid,
    output logic                  s1_wready,
    input  logic                  s1_wlast,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,
    output logic [ID_WIDTH-1:0]   s1_bid,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [ID_WIDTH-1:0]   s1_rid,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ID_WIDTH:0]     m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ID_WIDTH:0]     m_awid,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [ID_WIDTH:0]     m_bid,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [ID_WIDTH:0]     m_rid
);
    localparam int IDM = ID_WIDTH;

    logic ar_prio, ar_lock, ar_sel, ar_grant, ar_hs;
    logic aw_prio, aw_lock, aw_sel, aw_grant, aw_hs;
    logic wf_full, wf_empty, wf_head, wf_pop;
    logic r_dst, b_dst;

    // A presented-but-unaccepted request keeps its grant until the handshake.
    function automatic logic arb_grant(input logic lock, input logic sel, input logic prio,
                                       input logic v0, input logic v1);
        logic vp;
        vp = prio ? v1 : v0;
        if (lock)
            return sel;
        return vp ? prio : ~prio;
    endfunction

    assign ar_grant = arb_grant(ar_lock, ar_sel, ar_prio, s0_arvalid, s1_arvalid);
    assign aw_grant = arb_grant(aw_lock, aw_sel, aw_prio, s0_awvalid, s1_awvalid);
    assign ar_hs    = m_arvalid && m_arready;
    assign aw_hs    = m_awvalid && m_awready;
    assign wf_pop   = m_wvalid && m_wready && m_wlast;
    assign r_dst    = m_rid[IDM];
    assign b_dst    = m_bid[IDM];

    always_comb begin
        m_arvalid = 1'b0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_awvalid = 1'b0; m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
        s0_arready = 1'b0; s1_arready = 1'b0; s0_awready = 1'b0; s1_awready = 1'b0;
        m_wvalid = 1'b0; m_wlast = 1'b0; s0_wready = 1'b0; s1_wready = 1'b0;
        s0_rvalid = 1'b0; s1_rvalid = 1'b0; s0_rid = '0; s1_rid = '0; m_rready = 1'b0;
        s0_bvalid = 1'b0; s1_bvalid = 1'b0; s0_bid = '0; s1_bid = '0; m_bready = 1'b0;
        if (!rst) begin
            m_arvalid  = ar_grant ? s1_arvalid : s0_arvalid;
            m_arid     = {ar_grant, (ar_grant ? s1_arid : s0_arid)};
            m_araddr   = ar_grant ? s1_araddr  : s0_araddr;
            m_arlen    = ar_grant ? s1_arlen   : s0_arlen;
            m_arsize   = ar_grant ? s1_arsize  : s0_arsize;
            m_arburst  = ar_grant ? s1_arburst : s0_arburst;
            s0_arready = !ar_grant && m_arready;
            s1_arready = ar_grant && m_arready;

            // No AW may be accepted while its route could not be recorded.
            m_awvalid  = (aw_grant ? s1_awvalid : s0_awvalid) && !wf_full;
            m_awid     = {aw_grant, (aw_grant ? s1_awid : s0_awid)};
            m_awaddr   = aw_grant ? s1_awaddr  : s0_awaddr;
            m_awlen    = aw_grant ? s1_awlen   : s0_awlen;
            m_awsize   = aw_grant ? s1_awsize  : s0_awsize;
            m_awburst  = aw_grant ? s1_awburst : s0_awburst;
            s0_awready = !aw_grant && m_awready && !wf_full;
            s1_awready = aw_grant && m_awready && !wf_full;

            m_wvalid   = !wf_empty && (wf_head ? s1_wvalid : s0_wvalid);
            m_wlast    = wf_head ? s1_wlast : s0_wlast;
            s0_wready  = !wf_empty && !wf_head && m_wready;
            s1_wready  = !wf_empty && wf_head && m_wready;

            s0_rvalid  = !r_dst && m_rvalid;
            s1_rvalid  = r_dst && m_rvalid;
            s0_rid     = r_dst ? '0 : m_rid[IDM-1:0];
            s1_rid     = r_dst ? m_rid[IDM-1:0] : '0;
            m_rready   = r_dst ? s1_rready : s0_rready;

            s0_bvalid  = !b_dst && m_bvalid;
            s1_bvalid  = b_dst && m_bvalid;
            s0_bid     = b_dst ? '0 : m_bid[IDM-1:0];
            s1_bid     = b_dst ? m_bid[IDM-1:0] : '0;
            m_bready   = b_dst ? s1_bready : s0_bready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_prio <= 1'b0; ar_lock <= 1'b0; ar_sel <= 1'b0;
            aw_prio <= 1'b0; aw_lock <= 1'b0; aw_sel <= 1'b0;
        end else begin
            if (ar_hs) begin
                ar_lock <= 1'b0;
                ar_prio <= ~ar_grant;
            end else if (m_arvalid) begin
                ar_lock <= 1'b1;
                ar_sel  <= ar_grant;
            end
            if (aw_hs) begin
                aw_lock <= 1'b0;
                aw_prio <= ~aw_grant;
            end else if (m_awvalid) begin
                aw_lock <= 1'b1;
                aw_sel  <= aw_grant;
            end
        end
    end

    emulib_rammodel_route_fifo #(
        .DEPTH (W_FIFO_DEPTH)
    ) u_route_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (aw_hs),
        .din   (aw_grant),
        .pop   (wf_pop),
        .dout  (wf_head),
        .full  (wf_full),
        .empty (wf_empty)
    );
endmodule

// File: tb/tb_emulib_rammodel_arbiter_2to1.sv
// Randomized bench for emulib_rammodel_arbiter_2to1 with a queue-based scoreboard
// and a transaction-level reference model of grants, routing and FIFO occupancy.
module tb_emulib_rammodel_arbiter_2to1;
    localparam int IW    = 4;
    localparam int DEPTH = 2;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } req_t;

    typedef struct {
        logic src;
        int   len;
    } route_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]         arv, awv, wv, wl, rri, bri;
    logic [1:0][IW-1:0] arid, awid;
    logic [1:0][31:0]   araddr, awaddr;
    logic [1:0][7:0]    arlen, awlen;
    logic [1:0][2:0]    arsize, awsize;
    logic [1:0][1:0]    arburst, awburst;
    logic [1:0]         arr, awr, wr, rv, bv;
    logic [1:0][IW-1:0] rid, bid;

    logic          m_arvalid, m_arready, m_awvalid, m_awready;
    logic          m_wvalid, m_wready, m_wlast;
    logic          m_bvalid, m_bready, m_rvalid, m_rready;
    logic [IW:0]   m_arid, m_awid, m_bid, m_rid;
    logic [31:0]   m_araddr, m_awaddr;
    logic [7:0]    m_arlen, m_awlen;
    logic [2:0]    m_arsize, m_awsize;
    logic [1:0]    m_arburst, m_awburst;

    emulib_rammodel_arbiter_2to1 #(
        .ADDR_WIDTH (32), .ID_WIDTH (IW), .W_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst (rst),
        .s0_arvalid (arv[0]), .s0_arready (arr[0]), .s0_arid (arid[0]), .s0_araddr (araddr[0]),
        .s0_arlen (arlen[0]), .s0_arsize (arsize[0]), .s0_arburst (arburst[0]),
        .s0_awvalid (awv[0]), .s0_awready (awr[0]), .s0_awid (awid[0]), .s0_awaddr (awaddr[0]),
        .s0_awlen (awlen[0]), .s0_awsize (awsize[0]), .s0_awburst (awburst[0]),
        .s0_wvalid (wv[0]), .s0_wready (wr[0]), .s0_wlast (wl[0]),
        .s0_bvalid (bv[0]), .s0_bready (bri[0]), .s0_bid (bid[0]),
        .s0_rvalid (rv[0]), .s0_rready (rri[0]), .s0_rid (rid[0]),
        .s1_arvalid (arv[1]), .s1_arready (arr[1]), .s1_arid (arid[1]), .s1_araddr (araddr[1]),
        .s1_arlen (arlen[1]), .s1_arsize (arsize[1]), .s1_arburst (arburst[1]),
        .s1_awvalid (awv[1]), .s1_awready (awr[1]), .s1_awid (awid[1]), .s1_awaddr (awaddr[1]),
        .s1_awlen (awlen[1]), .s1_awsize (awsize[1]), .s1_awburst (awburst[1]),
        .s1_wvalid (wv[1]), .s1_wready (wr[1]), .s1_wlast (wl[1]),
        .s1_bvalid (bv[1]), .s1_bready (bri[1]), .s1_bid (bid[1]),
        .s1_rvalid (rv[1]), .s1_rready (rri[1]), .s1_rid (rid[1]),
        .m_arvalid (m_arvalid), .m_arready (m_arready), .m_arid (m_arid), .m_araddr (m_araddr),
        .m_arlen (m_arlen), .m_arsize (m_arsize), .m_arburst (m_arburst),
        .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awid (m_awid), .m_awaddr (m_awaddr),
        .m_awlen (m_awlen), .m_awsize (m_awsize), .m_awburst (m_awburst),
        .m_wvalid (m_wvalid), .m_wready (m_wready), .m_wlast (m_wlast),
        .m_bvalid (m_bvalid), .m_bready (m_bready), .m_bid (m_bid),
        .m_rvalid (m_rvalid), .m_rready (m_rready), .m_rid (m_rid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Scoreboard state: expected requests per requester, and the model of routed bursts.
    req_t   exp_ar[2][$];
    req_t   exp_aw[2][$];
    int     wq[2][$];
    int     wbeat[2];
    route_t mq[$];
    int     mbeat = 0;
    logic [IW:0] ar_seq[$];

    bit   mon_en = 1'b0;
    int   pv, pr, pw;
    bit   issue, fix_id;

    logic ar_busy = 1'b0, ar_other = 1'b0, ar_sw = 1'b0, ar_last = 1'b1;
    logic aw_busy = 1'b0, aw_other = 1'b0, aw_sw = 1'b0, aw_last = 1'b1;
    logic [31:0] ar_saddr, aw_saddr;

    function automatic req_t new_req(input bit fix);
        req_t q;
        q.id    = fix ? IW'(3) : IW'($urandom);
        q.addr  = $urandom;
        q.len   = 8'($urandom_range(0, 3));
        q.size  = 3'($urandom);
        q.burst = 2'($urandom);
        return q;
    endfunction

    function automatic bit coin(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic cycle();
        logic [1:0] har, haw, hw;
        req_t q;
        @(negedge clk);
        har = arv & arr;
        haw = awv & awr;
        hw  = wv & wr;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            if (har[r]) arv[r] = 1'b0;
            if (!arv[r] && issue && coin(pv)) begin
                q = new_req(fix_id);
                arv[r] = 1'b1; arid[r] = q.id; araddr[r] = q.addr;
                arlen[r] = q.len; arsize[r] = q.size; arburst[r] = q.burst;
                exp_ar[r].push_back(q);
            end
            if (haw[r]) awv[r] = 1'b0;
            if (!awv[r] && issue && coin(pv)) begin
                q = new_req(fix_id);
                awv[r] = 1'b1; awid[r] = q.id; awaddr[r] = q.addr;
                awlen[r] = q.len; awsize[r] = q.size; awburst[r] = q.burst;
                exp_aw[r].push_back(q);
                wq[r].push_back(int'(q.len));
            end
            if (hw[r]) begin
                wv[r] = 1'b0;
                if (wbeat[r] == wq[r][0]) begin
                    void'(wq[r].pop_front());
                    wbeat[r] = 0;
                end else begin
                    wbeat[r]++;
                end
            end
            if (!wv[r] && wq[r].size() > 0 && coin(pw)) wv[r] = 1'b1;
            wl[r]  = (wq[r].size() > 0) ? (wbeat[r] == wq[r][0]) : 1'b0;
            rri[r] = coin(pr);
            bri[r] = coin(pr);
        end
        m_arready = coin(pr);
        m_awready = coin(pr);
        m_wready  = coin(pr);
        m_rvalid  = 1'($urandom);
        m_rid     = (IW + 1)'($urandom);
        m_bvalid  = 1'($urandom);
        m_bid     = (IW + 1)'($urandom);
    endtask

    always @(negedge clk) begin : monitor
        req_t q;
        logic w, src, hok;
        if (mon_en) begin
            // AR channel
            chk("ar_valid", 64'(m_arvalid), 64'(arv[0] | arv[1]));
            if (m_arvalid && !ar_busy) begin
                ar_busy = 1'b1; ar_sw = m_arid[IW]; ar_saddr = m_araddr; ar_other = arv[!m_arid[IW]];
            end
            if (m_arvalid && m_arready) begin
                w = m_arid[IW];
                chk("ar_stable", 64'({w, m_araddr}), 64'({ar_sw, ar_saddr}));
                chk("ar_ready_route", 64'(arr), 64'(2'b01 << w));
                if (ar_other) chk("ar_fair", 64'(w), 64'(!ar_last));
                chk("ar_expected", 64'(exp_ar[w].size() != 0), 64'(1));
                if (exp_ar[w].size() != 0) begin
                    q = exp_ar[w].pop_front();
                    chk("ar_payload", 64'({m_arid[IW-1:0], m_araddr, m_arlen, m_arsize, m_arburst}),
                        64'({q.id, q.addr, q.len, q.size, q.burst}));
                end
                if (ar_seq.size() < 4) ar_seq.push_back(m_arid);
                ar_last = w;
                ar_busy = 1'b0;
            end

            // AW channel gating uses occupancy before this cycle's pop (no bypass)
            chk("aw_valid", 64'(m_awvalid), 64'((mq.size() < DEPTH) && (awv[0] | awv[1])));

            // W routing
            hok = (mq.size() > 0);
            src = hok ? mq[0].src : 1'b0;
            chk("w_valid", 64'(m_wvalid), 64'(hok && wv[src]));
            chk("w_ready", 64'(wr), 64'((hok && m_wready) ? (2'b01 << src) : 2'b00));
            if (m_wvalid && m_wready && hok) begin
                chk("w_last", 64'(m_wlast), 64'(mbeat == mq[0].len));
                if (mbeat == mq[0].len) begin
                    void'(mq.pop_front());
                    mbeat = 0;
                end else begin
                    mbeat++;
                end
            end

            if (m_awvalid && !aw_busy) begin
                aw_busy = 1'b1; aw_sw = m_awid[IW]; aw_saddr = m_awaddr; aw_other = awv[!m_awid[IW]];
            end
            if (m_awvalid && m_awready) begin
                w = m_awid[IW];
                chk("aw_stable", 64'({w, m_awaddr}), 64'({aw_sw, aw_saddr}));
                chk("aw_ready_route", 64'(awr), 64'(2'b01 << w));
                if (aw_other) chk("aw_fair", 64'(w), 64'(!aw_last));
                chk("aw_expected", 64'(exp_aw[w].size() != 0), 64'(1));
                if (exp_aw[w].size() != 0) begin
                    q = exp_aw[w].pop_front();
                    chk("aw_payload", 64'({m_awid[IW-1:0], m_awaddr, m_awlen, m_awsize, m_awburst}),
                        64'({q.id, q.addr, q.len, q.size, q.burst}));
                    mq.push_back('{src: w, len: int'(q.len)});
                end
                aw_last = w;
                aw_busy = 1'b0;
            end

            // Return paths
            chk("r_valid", 64'(rv), 64'(m_rvalid ? (2'b01 << m_rid[IW]) : 2'b00));
            if (m_rvalid) chk("r_id", 64'(rid[m_rid[IW]]), 64'(m_rid[IW-1:0]));
            chk("r_ready", 64'(m_rready), 64'(rri[m_rid[IW]]));
            chk("b_valid", 64'(bv), 64'(m_bvalid ? (2'b01 << m_bid[IW]) : 2'b00));
            if (m_bvalid) chk("b_id", 64'(bid[m_bid[IW]]), 64'(m_bid[IW-1:0]));
            chk("b_ready", 64'(m_bready), 64'(bri[m_bid[IW]]));
        end
    end

    logic [IW:0] cexp [4];

    initial begin
        cexp = '{5'h03, 5'h13, 5'h03, 5'h13};
        wbeat[0] = 0; wbeat[1] = 0;
        // Reset with every input asserted
        rst = 1'b1;
        arv = '1; awv = '1; wv = '1; wl = '1; rri = '1; bri = '1;
        arid = '1; awid = '1; araddr = '1; awaddr = '1; arlen = '1; awlen = '1;
        arsize = '1; awsize = '1; arburst = '1; awburst = '1;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        m_rvalid = 1'b1; m_bvalid = 1'b1; m_rid = '1; m_bid = '1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid_ready", 64'({m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready,
                                        arr, awr, wr, rv, bv}), 64'(0));
            chk("rst_addr", 64'({m_araddr, m_awaddr}), 64'(0));
            chk("rst_payload", 64'({m_arid, m_awid, rid, bid, m_arlen, m_awlen,
                                    m_arsize, m_awsize, m_arburst, m_awburst}), 64'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        arv = '0; awv = '0; wv = '0; wl = '0;
        m_rvalid = 1'b0; m_bvalid = 1'b0;
        mon_en = 1'b1;

        // Contention: both requesters continuously request with arid=3
        pv = 100; pr = 100; pw = 100; issue = 1'b1; fix_id = 1'b1;
        repeat (12) cycle();
        chk("contention_count", 64'(ar_seq.size() >= 4), 64'(1));
        for (int i = 0; i < ar_seq.size(); i++)
            chk("contention_arid", 64'(ar_seq[i]), 64'(cexp[i]));

        // Random traffic with backpressure, locks and FIFO-full episodes
        fix_id = 1'b0; pv = 45; pr = 55; pw = 60;
        repeat (3000) cycle();

        // Drain everything outstanding
        issue = 1'b0; pr = 100; pw = 100;
        repeat (300) cycle();
        chk("drain_ar0", 64'(exp_ar[0].size()), 64'(0));
        chk("drain_ar1", 64'(exp_ar[1].size()), 64'(0));
        chk("drain_aw0", 64'(exp_aw[0].size()), 64'(0));
        chk("drain_aw1", 64'(exp_aw[1].size()), 64'(0));
        chk("drain_route", 64'(mq.size()), 64'(0));

        // Directed return routing
        @(posedge clk);
        #1;
        m_rvalid = 1'b1; m_rid = 5'h1A; rri = 2'b10;
        m_bvalid = 1'b1; m_bid = 5'h05; bri = 2'b01;
        #1;
        chk("ret_s1_rvalid", 64'(rv[1]), 64'(1));
        chk("ret_s1_rid", 64'(rid[1]), 64'(4'hA));
        chk("ret_s0_rvalid", 64'(rv[0]), 64'(0));
        chk("ret_rready", 64'(m_rready), 64'(1));
        chk("ret_s0_bvalid", 64'(bv[0]), 64'(1));
        chk("ret_s0_bid", 64'(bid[0]), 64'(4'h5));
        chk("ret_bready", 64'(m_bready), 64'(1));
        rri = 2'b01;
        #1;
        chk("ret_rready_follow", 64'(m_rready), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
